// File: rtl/uart_wbs_pkg.sv
// Shared types and constants for the Wishbone-slave to register-bus bridge.
package uart_wbs_pkg;

    localparam int unsigned WB_AW  = 32;
    localparam int unsigned WB_DW  = 32;
    localparam int unsigned WB_SW  = 4;
    localparam int unsigned REG_AW = 9;

    // Window decode compares only the address bits above the register space.
    localparam int unsigned ADR_CMP_MSB = 31;
    localparam int unsigned ADR_CMP_LSB = 9;

    localparam logic [7:0] DEFAULT_TIMEOUT_CYC = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [REG_AW-1:0] addr;
        logic [WB_DW-1:0]  wdata;
        logic [WB_SW-1:0]  be;
    } reg_req_t;

endpackage

// File: rtl/uart_wbs_bridge_if.sv
// Wishbone classic slave port plus register-bus initiator port of the bridge.
interface uart_wbs_bridge_if;
    import uart_wbs_pkg::*;

    logic                wbs_cyc_i;
    logic                wbs_stb_i;
    logic [WB_AW-1:0]    wbs_adr_i;
    logic                wbs_we_i;
    logic [WB_DW-1:0]    wbs_dat_i;
    logic [WB_SW-1:0]    wbs_sel_i;
    logic [WB_DW-1:0]    wbs_dat_o;
    logic                wbs_ack_o;
    logic                wbs_err_o;

    logic                reg_cs;
    logic                reg_wr;
    logic [REG_AW-1:0]   reg_addr;
    logic [WB_DW-1:0]    reg_wdata;
    logic [WB_SW-1:0]    reg_be;
    logic [WB_DW-1:0]    reg_rdata;
    logic                reg_ack;

    // Bridge side.
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
        input  reg_rdata, reg_ack,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );

    // Environment side: Wishbone master and register-bus target.
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
        output reg_rdata, reg_ack,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );

endinterface

// File: rtl/uart_wbs_bridge.sv
// Wishbone classic slave to single-outstanding register-bus bridge.
// Optional reg_ack timeout is built when UART_WBS_TIMEOUT_EN is defined.
module uart_wbs_bridge
    import uart_wbs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter logic [7:0]  TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic             app_clk,
    input  logic             reset_ssn,
    uart_wbs_bridge_if.slave bus
);

    state_e             state_q;
    reg_req_t           req_q;
    logic               cs_q;
    logic               ack_q;
    logic               err_q;
    logic [WB_DW-1:0]   dat_q;
    logic               in_window_c;
    logic               timeout_hit_c;

    assign in_window_c = (bus.wbs_adr_i[ADR_CMP_MSB:ADR_CMP_LSB] ==
                          BASE_ADDR[ADR_CMP_MSB:ADR_CMP_LSB]);

`ifdef UART_WBS_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       busy_c;

    assign busy_c        = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign timeout_hit_c = busy_c && !bus.reg_ack &&
                           ((9'(tmo_cnt_q) + 9'd1) >= 9'(TIMEOUT_CYC));

    // Counter sits at zero outside REQ/DRAIN and restarts when REQ falls into DRAIN.
    always_ff @(posedge app_clk or negedge reset_ssn) begin
        if (!reset_ssn) begin
            tmo_cnt_q <= 8'd0;
        end else if (!busy_c) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == ST_REQ && !bus.reg_ack && !bus.wbs_cyc_i) begin
            tmo_cnt_q <= 8'd0;
        end else if (!bus.reg_ack) begin
            tmo_cnt_q <= 8'(tmo_cnt_q + 8'd1);
        end
    end
`else
    logic unused_timeout_cyc;

    assign timeout_hit_c      = 1'b0;
    assign unused_timeout_cyc = &{1'b0, TIMEOUT_CYC};
`endif

    // Transfer FSM; every bus-facing output is a flop updated here.
    always_ff @(posedge app_clk or negedge reset_ssn) begin
        if (!reset_ssn) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            cs_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        if (in_window_c) begin
                            req_q.wr    <= bus.wbs_we_i;
                            req_q.addr  <= bus.wbs_adr_i[REG_AW-1:0];
                            req_q.wdata <= bus.wbs_dat_i;
                            req_q.be    <= bus.wbs_sel_i;
                            cs_q        <= 1'b1;
                            state_q     <= ST_REQ;
                        end else begin
                            err_q   <= 1'b1;
                            dat_q   <= '0;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.reg_ack) begin
                        cs_q  <= 1'b0;
                        dat_q <= req_q.wr ? '0 : bus.reg_rdata;
                        if (bus.wbs_cyc_i) begin
                            ack_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!bus.wbs_cyc_i) begin
                        state_q <= ST_DRAIN;
                    end else if (timeout_hit_c) begin
                        cs_q    <= 1'b0;
                        err_q   <= 1'b1;
                        dat_q   <= '0;
                        state_q <= ST_RESP;
                    end
                end
                // Master walked away: finish the register access silently.
                ST_DRAIN: begin
                    if (bus.reg_ack || timeout_hit_c) begin
                        cs_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.reg_cs    = cs_q;
    assign bus.reg_wr    = req_q.wr;
    assign bus.reg_addr  = req_q.addr;
    assign bus.reg_wdata = req_q.wdata;
    assign bus.reg_be    = req_q.be;
    assign bus.wbs_dat_o = dat_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_err_o = err_q;

endmodule

// File: tb/tb_uart_wbs_bridge.sv
// Bench for uart_wbs_bridge: directed cases plus random transfers against a
// transaction-level expectation model.
module tb_uart_wbs_bridge;

    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam int          TMO    = 16;
    localparam int          BUDGET = 300;
    localparam int          NO_ACK = 1000;

    logic app_clk = 1'b0;
    logic reset_ssn;

    uart_wbs_bridge_if bus ();

    uart_wbs_bridge #(
        .BASE_ADDR   (BASE),
        .TIMEOUT_CYC (8'(TMO))
    ) dut (
        .app_clk   (app_clk),
        .reset_ssn (reset_ssn),
        .bus       (bus)
    );

    always #5 app_clk = ~app_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          resp_k;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        int          cs_n;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one Wishbone transfer. lead=1 when the request is
    // already on the bus during the previous transfer's response cycle.
    function automatic exp_t predict(input logic [31:0] addr, input logic we, input int d,
                                     input logic [31:0] rdata, input int lead);
        exp_t e;
        logic in_win;
        in_win = ((addr / 32'd512) == (BASE / 32'd512));
        if (!in_win) begin
            e.resp_k = lead + 1; e.ack = 1'b0; e.err = 1'b1; e.dat = '0; e.cs_n = 0;
        end else if (d >= TMO) begin
            e.resp_k = lead + 1 + TMO; e.ack = 1'b0; e.err = 1'b1; e.dat = '0; e.cs_n = TMO;
        end else begin
            e.resp_k = lead + 2 + d; e.ack = 1'b1; e.err = 1'b0;
            e.dat = we ? 32'h0 : rdata; e.cs_n = d + 1;
        end
        return e;
    endfunction

    task automatic xfer(input string tag, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdat, input logic [3:0] sel, input int d,
                        input logic [31:0] rdata, input int lead, input bit keep);
        exp_t        e;
        int          cs_n = 0;
        int          resp_k = 0;
        bit          both = 1'b0;
        bit          stable = 1'b1;
        logic        o_ack, o_err;
        logic [31:0] o_dat;
        logic [8:0]  a0;
        logic        w0;
        logic [31:0] wd0;
        logic [3:0]  be0;
        e = predict(addr, we, d, rdata, lead);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = addr;
        bus.wbs_we_i = we; bus.wbs_dat_i = wdat; bus.wbs_sel_i = sel;
        for (int k = 1; k <= BUDGET && resp_k == 0; k++) begin
            @(negedge app_clk);
            if (bus.wbs_ack_o && bus.wbs_err_o) both = 1'b1;
            if (bus.reg_cs) begin
                if (cs_n == 0) begin
                    a0 = bus.reg_addr; w0 = bus.reg_wr; wd0 = bus.reg_wdata; be0 = bus.reg_be;
                end else if ({bus.reg_addr, bus.reg_wr, bus.reg_wdata, bus.reg_be} !== {a0, w0, wd0, be0}) begin
                    stable = 1'b0;
                end
                cs_n++;
                bus.reg_ack   = (cs_n == d + 1);
                bus.reg_rdata = (cs_n == d + 1) ? rdata : $urandom;
            end else begin
                bus.reg_ack = 1'b0;
            end
            if (bus.wbs_ack_o || bus.wbs_err_o) begin
                resp_k = k; o_ack = bus.wbs_ack_o; o_err = bus.wbs_err_o; o_dat = bus.wbs_dat_o;
            end
        end
        check({tag, "_latency"}, 32'(resp_k), 32'(e.resp_k));
        check({tag, "_ack"},     32'(o_ack),  32'(e.ack));
        check({tag, "_err"},     32'(o_err),  32'(e.err));
        check({tag, "_dat"},     o_dat,       e.dat);
        check({tag, "_cs_cyc"},  32'(cs_n),   32'(e.cs_n));
        check({tag, "_exclusive"}, 32'(both), 32'(0));
        check({tag, "_stable"},  32'(stable), 32'(1));
        if (e.cs_n > 0) begin
            check({tag, "_reg_addr"},  32'(a0),  addr % 32'd512);
            check({tag, "_reg_wr"},    32'(w0),  32'(we));
            check({tag, "_reg_wdata"}, wd0,      wdat);
            check({tag, "_reg_be"},    32'(be0), 32'(sel));
        end
        if (!keep) begin
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
            @(negedge app_clk);
            check({tag, "_pulse_end"}, 32'({bus.wbs_ack_o, bus.wbs_err_o, bus.reg_cs}), 32'(0));
        end
    endtask

    initial begin : stim
        int          cs_n;
        bit          saw;
        logic [31:0] addr;
        reset_ssn = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_adr_i = '0; bus.wbs_we_i = 1'b0;
        bus.wbs_dat_i = '0; bus.wbs_sel_i = '0; bus.reg_rdata = '0; bus.reg_ack = 1'b0;
        repeat (3) @(negedge app_clk);
        check("rst_reg_cs",    32'(bus.reg_cs),    32'(0));
        check("rst_reg_wr",    32'(bus.reg_wr),    32'(0));
        check("rst_reg_addr",  32'(bus.reg_addr),  32'(0));
        check("rst_reg_wdata", bus.reg_wdata,      32'(0));
        check("rst_reg_be",    32'(bus.reg_be),    32'(0));
        check("rst_dat",       bus.wbs_dat_o,      32'(0));
        check("rst_ack_err",   32'({bus.wbs_ack_o, bus.wbs_err_o}), 32'(0));
        reset_ssn = 1'b1;
        @(negedge app_clk);

        xfer("wr_0x10", 32'h1001_0010, 1'b1, 32'h0000_00A5, 4'hF, 2, 32'hDEAD_BEEF, 0, 1'b0);
        xfer("rd_0x08", 32'h1001_0008, 1'b0, 32'h1357_9BDF, 4'hF, 0, 32'h0000_0055, 0, 1'b0);
        xfer("rd_oow",  32'h2000_0000, 1'b0, 32'h0,         4'hF, 0, 32'h1234_5678, 0, 1'b0);
        xfer("rd_top",  32'h1001_01FC, 1'b0, 32'h0,         4'h3, 1, 32'hCAFE_F00D, 0, 1'b0);
        xfer("rd_above",32'h1001_0200, 1'b0, 32'h0,         4'hF, 0, 32'h1111_1111, 0, 1'b0);
        xfer("wr_below",32'h1000_FFFC, 1'b1, 32'h5A5A_5A5A, 4'hF, 0, 32'h0,         0, 1'b0);

        // Back-to-back reads: second request is on the bus during the first's ack cycle.
        xfer("b2b_a", 32'h1001_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0000_1111, 0, 1'b1);
        xfer("b2b_b", 32'h1001_000C, 1'b0, 32'h0, 4'hF, 0, 32'h0000_2222, 1, 1'b0);

        // Master abandons the cycle one cycle into REQ; reg_ack comes after 5 more.
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h1001_0020;
        bus.wbs_we_i = 1'b1; bus.wbs_dat_i = 32'h0000_00C3; bus.wbs_sel_i = 4'h1;
        cs_n = 0; saw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge app_clk);
            if (bus.wbs_ack_o || bus.wbs_err_o) saw = 1'b1;
            if (k == 1) begin bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; end
            if (bus.reg_cs) begin
                cs_n++;
                bus.reg_ack = (cs_n == 6);
            end else begin
                bus.reg_ack = 1'b0;
            end
        end
        check("drain_cs_cyc",  32'(cs_n),       32'(6));
        check("drain_no_resp", 32'(saw),        32'(0));
        check("drain_cs_low",  32'(bus.reg_cs), 32'(0));
        xfer("after_drain", 32'h1001_0024, 1'b0, 32'h0, 4'hF, 1, 32'h7777_0001, 0, 1'b0);

        // Stray reg_ack while idle must not start anything.
        saw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.reg_ack = 1'b1; bus.reg_rdata = $urandom;
            @(negedge app_clk);
            if (bus.wbs_ack_o || bus.wbs_err_o || bus.reg_cs) saw = 1'b1;
        end
        bus.reg_ack = 1'b0;
        check("idle_stray_ack", 32'(saw), 32'(0));

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) addr = BASE | ($urandom & 32'h0000_01FC);
            else addr = $urandom;
            xfer($sformatf("rnd%0d", n), addr, 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom), $urandom_range(0, 4), $urandom, 0, 1'b0);
        end

        // Reset while a register access is outstanding.
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h1001_0040;
        bus.wbs_we_i = 1'b1; bus.wbs_dat_i = 32'hFFFF_0000; bus.wbs_sel_i = 4'hC;
        @(negedge app_clk);
        check("rstmid_cs_before", 32'(bus.reg_cs), 32'(1));
        reset_ssn = 1'b0;
        #1;
        check("rstmid_cs",    32'(bus.reg_cs),   32'(0));
        check("rstmid_addr",  32'(bus.reg_addr), 32'(0));
        check("rstmid_wdata", bus.reg_wdata,     32'(0));
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge app_clk);
        reset_ssn = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge app_clk);
            if (bus.wbs_ack_o || bus.wbs_err_o || bus.reg_cs) saw = 1'b1;
        end
        check("rstmid_silent", 32'(saw), 32'(0));

`ifdef UART_WBS_TIMEOUT_EN
        xfer("timeout", 32'h1001_0030, 1'b0, 32'h0, 4'hF, NO_ACK, 32'hBAD0_BAD0, 0, 1'b0);
        xfer("after_tmo", 32'h1001_0034, 1'b0, 32'h0, 4'hF, 0, 32'h0000_0099, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
